conv_lbxn: RTL and testbench
============================

CONV_LBXN -- requirements
Module: conv_lbxn

Interface
REQ-001 SHALL have parameter K, default 3: kernel height, rows per output column; legal 2..8.
REQ-002 SHALL have parameter W_MAX, default 1024: maximum pixels per line; power of two.
REQ-003 SHALL have parameter PAD_MODE, default conv_pkg::PAD_ZERO: fill for missing rows, PAD_ZERO or PAD_REPL.
REQ-004 SHALL have ports:
- clk  in  1  sole clock, all state on rising edge
- arst_n  in  1  asynchronous, active-low reset
- pixel_vld_i  in  1  input pixel valid; no backpressure
- pixel_dat_i  in  conv_pkg::pixel_t  input pixel
- pixel_sof_i  in  1  pixel is first of frame, qualified by pixel_vld_i
- pixel_eol_i  in  1  pixel is last of line, qualified by pixel_vld_i
- col_vld_o  out  1  output column valid
- col_dat_o  out  K x conv_pkg::pixel_t  index 0 is current row, index i is the row i lines above
- col_full_o  out  1  all K rows are real data, no padding
- col_eol_o  out  1  column is last of line
- err_ovf_o  out  1  sticky: line exceeded W_MAX
- err_len_o  out  1  sticky: line length differs from first line of frame

Function
REQ-005 SHALL hold K-1 line stores of W_MAX x pixel_t, rotated by a write pointer wp (0..K-2).
REQ-006 SHALL keep a column counter x (clog2(W_MAX) bits), line-fill counter rows (0..K-1, saturating) and first-line length len0.
REQ-007 SHALL implement FSM IDLE -> FILL on accepted pixel with pixel_sof_i; FILL -> RUN on eol when rows reaches K-1; RUN/FILL -> FILL on sof; ERR -> IDLE on sof only.
REQ-008 SHALL, in IDLE, ignore pixels without pixel_sof_i: no output, no state change.
REQ-009 SHALL give every accepted pixel exactly one column, col_vld_o asserted one cycle after pixel_vld_i (latency 1).
REQ-010 SHALL drive col_dat_o[0] with the accepted pixel, and col_dat_o[i] (1..K-1) with the store written i lines earlier at the same x.
REQ-011 SHALL write the accepted pixel into store wp at address x, read-before-write, so the oldest row is read out and replaced in the same cycle.
REQ-012 SHALL, for i > rows, drive col_dat_o[i] with zero under PAD_ZERO, or with col_dat_o[rows] under PAD_REPL.
REQ-013 SHALL assert col_full_o iff rows == K-1 at the time of the pixel.
REQ-014 SHALL, on eol: clear x, advance wp modulo K-1, increment rows (saturating), record len0 on the first line, and raise col_eol_o with that column.
REQ-015 SHALL treat pixel_sof_i as clearing x, rows and wp before that pixel is processed; sof and eol together form a one-pixel line.
REQ-016 SHALL, when x == W_MAX-1 without eol, set err_ovf_o, enter ERR, and drop pixels until the next sof.
REQ-017 SHALL, on eol of any line after the first where x+1 != len0, set err_len_o and keep processing.
REQ-018 SHALL clear error flags only on reset.

Reset
REQ-019 SHALL reset asynchronously on arst_n low: FSM IDLE, x=0, rows=0, wp=0, all outputs 0.
REQ-020 SHALL leave line-store contents undefined after reset; padding (REQ-012) masks them.
REQ-021 SHALL abandon any frame in progress on reset mid-line, with no column emitted for the reset cycle's pixel.

Structure
REQ-022 SHALL define pad_mode_t (PAD_ZERO, PAD_REPL) and the lbxn FSM state enum in conv_pkg, reusing pixel_t.
REQ-023 SHALL place each line store in sub-module conv_lbxn_line_mem: 1R1W, W_MAX deep, registered read, read-before-write.

Verification (K=3, W_MAX=8)
REQ-024 SHALL cover: frame of 3 lines width 4, pixels = 10*row+col, PAD_ZERO -> line 2 col 1 gives col_dat_o = {21,11,1}, col_full_o=1; line 0 gives {c,0,0}.
REQ-025 SHALL cover: same frame, PAD_REPL -> line 1 col 2 gives {12,2,2}, col_full_o=0.
REQ-026 SHALL cover: 9 pixels without eol -> err_ovf_o=1 after the 8th, 9th pixel gives no col_vld_o, next sof recovers.
REQ-027 SHALL cover: line lengths 4 then 3 -> err_len_o=1 at the second eol; columns still emitted.
REQ-028 SHALL cover: sof mid-line 2 -> next column padded as row 0 (col_full_o=0).
REQ-029 SHALL cover: arst_n pulsed mid-line -> outputs 0 next cycle; non-sof pixels ignored until a sof.

Source files
------------

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared pixel, padding and line-buffer FSM types
package conv_pkg;

    typedef logic [7:0] pixel_t;

    typedef enum logic {
        PAD_ZERO = 1'b0,
        PAD_REPL = 1'b1
    } pad_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_ERR  = 2'd3
    } lbxn_state_t;

endpackage

// File: rtl/conv_lbxn_line_mem.sv
// rtl/conv_lbxn_line_mem.sv - one line store, 1R1W, registered read-before-write
module conv_lbxn_line_mem
    import conv_pkg::*;
#(
    parameter int W_MAX = 1024,
    parameter int AW    = $clog2(W_MAX)
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  pixel_t        i_wdat,
    output pixel_t        o_rdat
);

    pixel_t r_mem [W_MAX];
    pixel_t r_rdat;

    // The read samples the old word even when the same address is written.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_rdat <= r_mem[i_addr];
            if (i_we) begin
                r_mem[i_addr] <= i_wdat;
            end
        end
    end

    assign o_rdat = r_rdat;

endmodule

// File: rtl/conv_lbxn.sv
// rtl/conv_lbxn.sv - K-row line buffer producing one vertical pixel column per input pixel
module conv_lbxn
    import conv_pkg::*;
#(
    parameter int        K        = 3,
    parameter int        W_MAX    = 1024,
    parameter pad_mode_t PAD_MODE = conv_pkg::PAD_ZERO
) (
    input  logic           clk,
    input  logic           arst_n,
    input  logic           pixel_vld_i,
    input  pixel_t         pixel_dat_i,
    input  logic           pixel_sof_i,
    input  logic           pixel_eol_i,
    output logic           col_vld_o,
    output pixel_t [K-1:0] col_dat_o,
    output logic           col_full_o,
    output logic           col_eol_o,
    output logic           err_ovf_o,
    output logic           err_len_o
);

    localparam int NS = K - 1;
    localparam int XW = $clog2(W_MAX);
    localparam int RW = $clog2(K);
    localparam int PW = (K > 2) ? $clog2(K - 1) : 1;

    localparam logic [XW-1:0] X_LAST   = XW'(W_MAX - 1);
    localparam logic [RW-1:0] ROWS_MAX = RW'(K - 1);
    localparam logic [PW-1:0] WP_LAST  = PW'(K - 2);

    lbxn_state_t r_state, w_state_nxt;
    logic [XW-1:0] r_x, w_x_nxt, w_x_eff;
    logic [RW-1:0] r_rows, w_rows_nxt, w_rows_eff;
    logic [PW-1:0] r_wp, w_wp_nxt, w_wp_eff;
    logic [XW:0]   r_len0, w_len0_nxt, w_len_cur;
    logic          w_acc, w_ovf, w_len_bad;

    logic          r_vld, r_full, r_eol, r_ovf, r_len;
    pixel_t        r_pix;
    logic [RW-1:0] r_rows_d;
    logic [PW-1:0] r_wp_d;

    pixel_t w_rd   [NS];
    pixel_t w_real [K];
    pixel_t w_repl;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A start-of-frame pixel sees a freshly cleared position before it is processed.
    always_comb begin
        w_state_nxt = r_state;
        w_x_eff     = pixel_sof_i ? '0 : r_x;
        w_rows_eff  = pixel_sof_i ? '0 : r_rows;
        w_wp_eff    = pixel_sof_i ? '0 : r_wp;
        w_len_cur   = {1'b0, w_x_eff} + (XW+1)'(1);
        w_x_nxt     = r_x;
        w_rows_nxt  = r_rows;
        w_wp_nxt    = r_wp;
        w_len0_nxt  = r_len0;
        case (r_state)
            ST_IDLE, ST_ERR: w_acc = pixel_vld_i && pixel_sof_i;
            default:         w_acc = pixel_vld_i;
        endcase
        w_ovf     = w_acc && !pixel_eol_i && (w_x_eff == X_LAST);
        w_len_bad = w_acc && pixel_eol_i && (w_rows_eff != '0) && (w_len_cur != r_len0);
        if (w_acc) begin
            w_x_nxt    = w_x_eff + XW'(1);
            w_rows_nxt = w_rows_eff;
            w_wp_nxt   = w_wp_eff;
            if (pixel_sof_i) begin
                w_state_nxt = ST_FILL;
            end
            if (pixel_eol_i) begin
                w_x_nxt    = '0;
                w_wp_nxt   = (w_wp_eff == WP_LAST) ? '0 : w_wp_eff + PW'(1);
                w_rows_nxt = (w_rows_eff == ROWS_MAX) ? ROWS_MAX : w_rows_eff + RW'(1);
                if (w_rows_eff == '0) begin
                    w_len0_nxt = w_len_cur;
                end
                w_state_nxt = (w_rows_nxt == ROWS_MAX) ? ST_RUN : ST_FILL;
            end else if (w_ovf) begin
                w_x_nxt     = '0;
                w_state_nxt = ST_ERR;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_x      <= '0;
            r_rows   <= '0;
            r_wp     <= '0;
            r_len0   <= '0;
            r_vld    <= 1'b0;
            r_full   <= 1'b0;
            r_eol    <= 1'b0;
            r_ovf    <= 1'b0;
            r_len    <= 1'b0;
            r_pix    <= '0;
            r_rows_d <= '0;
            r_wp_d   <= '0;
        end else begin
            r_x    <= w_x_nxt;
            r_rows <= w_rows_nxt;
            r_wp   <= w_wp_nxt;
            r_len0 <= w_len0_nxt;
            r_vld  <= w_acc;
            r_full <= w_acc && (w_rows_eff == ROWS_MAX);
            r_eol  <= w_acc && pixel_eol_i;
            if (w_ovf) begin
                r_ovf <= 1'b1;
            end
            if (w_len_bad) begin
                r_len <= 1'b1;
            end
            if (w_acc) begin
                r_pix    <= pixel_dat_i;
                r_rows_d <= w_rows_eff;
                r_wp_d   <= w_wp_eff;
            end
        end
    end

    // Every store is read each accepted pixel; only the current line's store is written.
    for (genvar gs = 0; gs < NS; gs++) begin : g_mem
        conv_lbxn_line_mem #(
            .W_MAX (W_MAX),
            .AW    (XW)
        ) u_mem (
            .clk    (clk),
            .i_en   (w_acc),
            .i_we   (w_wp_eff == PW'(gs)),
            .i_addr (w_x_eff),
            .i_wdat (pixel_dat_i),
            .o_rdat (w_rd[gs])
        );
    end

    assign w_real[0] = r_pix;

    // Row i above lives in store (wp - i) mod (K-1); wp itself holds the oldest row.
    for (genvar gi = 1; gi < K; gi++) begin : g_tap
        localparam logic [PW:0] OFF  = (PW+1)'(gi);
        localparam logic [PW:0] WRAP = (PW+1)'(K - 1 - gi);
        logic [PW:0] w_sel;
        assign w_sel = ({1'b0, r_wp_d} >= OFF) ? ({1'b0, r_wp_d} - OFF) : ({1'b0, r_wp_d} + WRAP);
        assign w_real[gi] = w_rd[w_sel[PW-1:0]];
    end

    assign w_repl = w_real[r_rows_d];

    always_comb begin
        col_dat_o    = '0;
        col_dat_o[0] = r_pix;
        for (int i = 1; i < K; i++) begin
            if (RW'(i) > r_rows_d) begin
                col_dat_o[i] = (PAD_MODE == PAD_REPL) ? w_repl : '0;
            end else begin
                col_dat_o[i] = w_real[i];
            end
        end
    end

    assign col_vld_o  = r_vld;
    assign col_full_o = r_full;
    assign col_eol_o  = r_eol;
    assign err_ovf_o  = r_ovf;
    assign err_len_o  = r_len;

endmodule

// File: tb/tb_conv_lbxn.sv
// tb/tb_conv_lbxn.sv - checks zero- and replicate-padded line buffers against a frame model
module tb_conv_lbxn;
    import conv_pkg::*;

    localparam int K  = 3;
    localparam int WM = 8;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    logic pixel_vld_i = 1'b0;
    pixel_t pixel_dat_i = '0;
    logic pixel_sof_i = 1'b0;
    logic pixel_eol_i = 1'b0;

    logic vld_z, full_z, eol_z, ovf_z, len_z;
    logic vld_r, full_r, eol_r, ovf_r, len_r;
    pixel_t [K-1:0] dat_z, dat_r;

    always #5 clk = ~clk;

    conv_lbxn #(.K(K), .W_MAX(WM), .PAD_MODE(PAD_ZERO)) dut_z (
        .clk(clk), .arst_n(arst_n), .pixel_vld_i(pixel_vld_i), .pixel_dat_i(pixel_dat_i),
        .pixel_sof_i(pixel_sof_i), .pixel_eol_i(pixel_eol_i), .col_vld_o(vld_z),
        .col_dat_o(dat_z), .col_full_o(full_z), .col_eol_o(eol_z),
        .err_ovf_o(ovf_z), .err_len_o(len_z));

    conv_lbxn #(.K(K), .W_MAX(WM), .PAD_MODE(PAD_REPL)) dut_r (
        .clk(clk), .arst_n(arst_n), .pixel_vld_i(pixel_vld_i), .pixel_dat_i(pixel_dat_i),
        .pixel_sof_i(pixel_sof_i), .pixel_eol_i(pixel_eol_i), .col_vld_o(vld_r),
        .col_dat_o(dat_r), .col_full_o(full_r), .col_eol_o(eol_r),
        .err_ovf_o(ovf_r), .err_len_o(len_r));

    int n_cmp = 0;
    int n_bad = 0;

    // Frame model: completed lines of the current frame, newest at index 1.
    bit m_in, m_ovf, m_len;
    int m_x, m_lines, m_len0;
    int hist_pix [1:K-1][0:WM-1];
    int hist_len [1:K-1];
    int cur_line [0:WM-1];

    bit e_vld, e_full, e_eol;
    int ez [K];
    int er [K];
    bit kz [K];
    bit kr [K];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_in = 0; m_ovf = 0; m_len = 0; m_x = 0; m_lines = 0; m_len0 = 0;
        e_vld = 0;
    endtask

    task automatic model(input bit v, input int d, input bit s, input bit e);
        int rows;
        int rv [K];
        bit rk [K];
        e_vld = 0;
        if (v && (m_in || s)) begin
            if (s) begin
                m_in = 1; m_x = 0; m_lines = 0;
            end
            rows = (m_lines < K - 1) ? m_lines : K - 1;
            e_vld = 1;
            e_full = (rows == K - 1);
            e_eol = e;
            rv[0] = d; rk[0] = 1;
            for (int i = 1; i < K; i++) begin
                rk[i] = (i <= rows) && (hist_len[i] > m_x);
                rv[i] = rk[i] ? hist_pix[i][m_x] : 0;
            end
            for (int i = 0; i < K; i++) begin
                if (i <= rows) begin
                    ez[i] = rv[i]; kz[i] = rk[i]; er[i] = rv[i]; kr[i] = rk[i];
                end else begin
                    ez[i] = 0; kz[i] = 1; er[i] = rv[rows]; kr[i] = rk[rows];
                end
            end
            cur_line[m_x] = d;
            if (e) begin
                if (m_lines == 0) m_len0 = m_x + 1;
                else if (m_x + 1 != m_len0) m_len = 1;
                for (int j = K - 1; j >= 2; j--) begin
                    hist_len[j] = hist_len[j-1];
                    for (int c = 0; c < WM; c++) hist_pix[j][c] = hist_pix[j-1][c];
                end
                hist_len[1] = m_x + 1;
                for (int c = 0; c < WM; c++) hist_pix[1][c] = cur_line[c];
                m_lines++;
                m_x = 0;
            end else if (m_x == WM - 1) begin
                m_ovf = 1; m_in = 0;
            end else begin
                m_x++;
            end
        end
    endtask

    task automatic check_out();
        chk("vld_z", vld_z, e_vld);
        chk("vld_r", vld_r, e_vld);
        if (e_vld) begin
            chk("eol_z", eol_z, e_eol);
            chk("eol_r", eol_r, e_eol);
            chk("full_z", full_z, e_full);
            chk("full_r", full_r, e_full);
            for (int i = 0; i < K; i++) begin
                if (kz[i]) chk($sformatf("dat_z[%0d]", i), dat_z[i], ez[i]);
                if (kr[i]) chk($sformatf("dat_r[%0d]", i), dat_r[i], er[i]);
            end
        end
        chk("ovf_z", ovf_z, m_ovf);
        chk("ovf_r", ovf_r, m_ovf);
        chk("len_z", len_z, m_len);
        chk("len_r", len_r, m_len);
    endtask

    task automatic step(input bit v, input int d, input bit s, input bit e);
        pixel_vld_i = v;
        pixel_dat_i = d[7:0];
        pixel_sof_i = s;
        pixel_eol_i = e;
        model(v, d, s, e);
        @(posedge clk);
        #1;
        pixel_vld_i = 1'b0;
        pixel_sof_i = 1'b0;
        pixel_eol_i = 1'b0;
        check_out();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_vld_z"}, vld_z, 0);
        chk({tag, "_vld_r"}, vld_r, 0);
        chk({tag, "_full_z"}, full_z, 0);
        chk({tag, "_eol_z"}, eol_z, 0);
        chk({tag, "_ovf_z"}, ovf_z, 0);
        chk({tag, "_len_z"}, len_z, 0);
        chk({tag, "_ovf_r"}, ovf_r, 0);
        chk({tag, "_len_r"}, len_r, 0);
        for (int i = 0; i < K; i++) begin
            chk($sformatf("%s_dat_z[%0d]", tag, i), dat_z[i], 0);
            chk($sformatf("%s_dat_r[%0d]", tag, i), dat_r[i], 0);
        end
    endtask

    task automatic reset_mid();
        pixel_vld_i = 1'b1;
        pixel_dat_i = 8'(1 + $urandom_range(0, 254));
        pixel_sof_i = 1'b1;
        pixel_eol_i = 1'b0;
        arst_n = 1'b0;
        model_reset();
        #1;
        check_zero("rst_async");
        @(posedge clk);
        #1;
        check_zero("rst_cycle");
        arst_n = 1'b1;
        pixel_vld_i = 1'b0;
        pixel_sof_i = 1'b0;
    endtask

    initial begin
        int w0, wl, nl;
        model_reset();
        for (int j = 1; j < K; j++) hist_len[j] = 0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        arst_n = 1'b1;

        step(1, 5, 0, 0);
        step(1, 6, 0, 1);

        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                step(1, 10 * r + c, (r == 0) && (c == 0), c == 3);
                if (r == 2 && c == 1) begin
                    chk("frm_l2c1_d0", dat_z[0], 21);
                    chk("frm_l2c1_d1", dat_z[1], 11);
                    chk("frm_l2c1_d2", dat_z[2], 1);
                    chk("frm_l2c1_full", full_z, 1);
                end
                if (r == 1 && c == 2) begin
                    chk("repl_l1c2_d0", dat_r[0], 12);
                    chk("repl_l1c2_d1", dat_r[1], 2);
                    chk("repl_l1c2_d2", dat_r[2], 2);
                    chk("repl_l1c2_full", full_r, 0);
                end
                if (r == 0) begin
                    chk("frm_l0_d0", dat_z[0], c);
                    chk("frm_l0_d1", dat_z[1], 0);
                    chk("frm_l0_d2", dat_z[2], 0);
                end
            end
        end

        for (int p = 1; p <= 9; p++) begin
            step(1, 100 + p, p == 1, 0);
            if (p == 8) chk("ovf_after_8", ovf_z, 1);
            if (p == 9) chk("ovf_drop_9", vld_z, 0);
        end
        step(1, 77, 1, 1);
        chk("ovf_recover", vld_z, 1);

        for (int c = 0; c < 4; c++) step(1, 40 + c, c == 0, c == 3);
        for (int c = 0; c < 3; c++) step(1, 50 + c, 0, c == 2);
        chk("len_err", len_z, 1);
        chk("len_col", vld_z, 1);

        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) step(1, 10 * r + c + 1, (r == 0) && (c == 0), c == 3);
        step(1, 60, 0, 0);
        step(1, 61, 0, 0);
        step(1, 99, 1, 0);
        chk("sofmid_full", full_z, 0);
        chk("sofmid_d1z", dat_z[1], 0);
        chk("sofmid_d1r", dat_r[1], 99);

        step(1, 70, 0, 0);
        reset_mid();
        step(1, 71, 0, 0);
        step(1, 72, 0, 1);
        chk("rst_ignore", vld_z, 0);
        step(1, 73, 1, 0);
        chk("rst_sof", vld_z, 1);

        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(0, 2)) step(0, $urandom_range(0, 255), $urandom_range(0, 1), 0);
            if ($urandom_range(0, 7) == 0) step(1, $urandom_range(0, 255), 0, $urandom_range(0, 1));
            if ($urandom_range(0, 24) == 0) reset_mid();
            nl = $urandom_range(1, 5);
            w0 = $urandom_range(1, WM);
            for (int r = 0; r < nl; r++) begin
                wl = ($urandom_range(0, 5) == 0) ? $urandom_range(1, WM) : w0;
                if ($urandom_range(0, 19) == 0) wl = WM + 1;
                for (int c = 0; c < wl; c++) begin
                    step(1, $urandom_range(0, 255), (r == 0) && (c == 0), (c == wl - 1) && (wl <= WM));
                    if ($urandom_range(0, 9) == 0) step(0, $urandom_range(0, 255), 0, 0);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
